// File: rtl/i_split4.sv
// 1:4 packet steering block for the response path: routes each whole packet
// to the output named by header SRC_ID[1:0], optionally popping that code.
module i_split4 #(
  parameter bit CONSUME_ROUTE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        I_TVALID,
  output logic        I_TREADY,
  input  logic [63:0] I_TDATA,
  input  logic        I_TLAST,
  output logic        O0_TVALID,
  input  logic        O0_TREADY,
  output logic [63:0] O0_TDATA,
  output logic        O0_TLAST,
  output logic        O1_TVALID,
  input  logic        O1_TREADY,
  output logic [63:0] O1_TDATA,
  output logic        O1_TLAST,
  output logic        O2_TVALID,
  input  logic        O2_TREADY,
  output logic [63:0] O2_TDATA,
  output logic        O2_TLAST,
  output logic        O3_TVALID,
  input  logic        O3_TREADY,
  output logic [63:0] O3_TDATA,
  output logic        O3_TLAST
);

  typedef struct packed {
    logic [1:0]  port;
    logic        last;
    logic [63:0] data;
  } ent_t;

  ent_t       mem_q [2];
  logic       wp_q, rp_q;
  logic [1:0] cnt_q, cnt_d;
  logic       hdr_q;
  logic [1:0] route_q;
  logic       rdy_q;

  ent_t       in_e, head;
  logic       push, pop, sel_rdy, hv;

  always_comb begin
    in_e      = '0;
    in_e.last = I_TLAST;
    in_e.data = I_TDATA;
    in_e.port = hdr_q ? I_TDATA[49:48] : route_q;
    if (hdr_q && CONSUME_ROUTE)
      in_e.data[55:48] = {2'b00, I_TDATA[55:50]};
  end

  assign head = mem_q[rp_q];
  assign hv   = (cnt_q != 2'd0);

  always_comb begin
    sel_rdy = 1'b0;
    unique case (head.port)
      2'd0: sel_rdy = O0_TREADY;
      2'd1: sel_rdy = O1_TREADY;
      2'd2: sel_rdy = O2_TREADY;
      2'd3: sel_rdy = O3_TREADY;
    endcase
  end

  assign push = I_TVALID && rdy_q;
  assign pop  = hv && sel_rdy;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Ready is a flop of the next occupancy, so it never depends on On_TREADY.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q    <= 1'b0;
      rp_q    <= 1'b0;
      cnt_q   <= 2'd0;
      hdr_q   <= 1'b1;
      route_q <= 2'd0;
      rdy_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      rdy_q <= (cnt_d != 2'd2);
      if (pop) rp_q <= ~rp_q;
      if (push) begin
        mem_q[wp_q] <= in_e;
        wp_q        <= ~wp_q;
        if (hdr_q) begin
          route_q <= I_TDATA[49:48];
          if (!I_TLAST) hdr_q <= 1'b0;
        end else if (I_TLAST) begin
          hdr_q <= 1'b1;
        end
      end
    end
  end

  assign I_TREADY  = rdy_q;
  assign O0_TVALID = hv && (head.port == 2'd0);
  assign O1_TVALID = hv && (head.port == 2'd1);
  assign O2_TVALID = hv && (head.port == 2'd2);
  assign O3_TVALID = hv && (head.port == 2'd3);
  assign O0_TDATA  = head.data;
  assign O1_TDATA  = head.data;
  assign O2_TDATA  = head.data;
  assign O3_TDATA  = head.data;
  assign O0_TLAST  = head.last;
  assign O1_TLAST  = head.last;
  assign O2_TLAST  = head.last;
  assign O3_TLAST  = head.last;

endmodule

// File: tb/tb_i_split4.sv
// Bench for i_split4: packet-level queue model checked every cycle on two
// instances (route code popped / passed), plus directed literal expectations.
module tb_i_split4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        I_TVALID = 1'b0;
  logic [63:0] I_TDATA = '0;
  logic        I_TLAST = 1'b0;
  logic [3:0]  trdy = 4'hF;
  logic        I_TREADY, I_TREADY0;
  logic [3:0]  ov, ov0, ol, ol0;
  logic [63:0] od [4];
  logic [63:0] od0 [4];

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  i_split4 #(.CONSUME_ROUTE(1'b1)) dut (
    .clk(clk), .reset(reset),
    .I_TVALID(I_TVALID), .I_TREADY(I_TREADY),
    .I_TDATA(I_TDATA), .I_TLAST(I_TLAST),
    .O0_TVALID(ov[0]), .O0_TREADY(trdy[0]),
    .O0_TDATA(od[0]), .O0_TLAST(ol[0]),
    .O1_TVALID(ov[1]), .O1_TREADY(trdy[1]),
    .O1_TDATA(od[1]), .O1_TLAST(ol[1]),
    .O2_TVALID(ov[2]), .O2_TREADY(trdy[2]),
    .O2_TDATA(od[2]), .O2_TLAST(ol[2]),
    .O3_TVALID(ov[3]), .O3_TREADY(trdy[3]),
    .O3_TDATA(od[3]), .O3_TLAST(ol[3])
  );

  i_split4 #(.CONSUME_ROUTE(1'b0)) dut0 (
    .clk(clk), .reset(reset),
    .I_TVALID(I_TVALID), .I_TREADY(I_TREADY0),
    .I_TDATA(I_TDATA), .I_TLAST(I_TLAST),
    .O0_TVALID(ov0[0]), .O0_TREADY(trdy[0]),
    .O0_TDATA(od0[0]), .O0_TLAST(ol0[0]),
    .O1_TVALID(ov0[1]), .O1_TREADY(trdy[1]),
    .O1_TDATA(od0[1]), .O1_TLAST(ol0[1]),
    .O2_TVALID(ov0[2]), .O2_TREADY(trdy[2]),
    .O2_TDATA(od0[2]), .O2_TLAST(ol0[2]),
    .O3_TVALID(ov0[3]), .O3_TREADY(trdy[3]),
    .O3_TDATA(od0[3]), .O3_TLAST(ol0[3])
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Model: queue of beats in flight, tagged with whether each was a header.
  typedef struct {
    logic [1:0]  port;
    logic        last;
    logic [63:0] raw;
    logic        hdr;
  } mbeat_t;

  mbeat_t     q[$];
  logic       m_in_hdr = 1'b1;
  logic [1:0] m_route = 2'd0;
  logic       m_ready = 1'b0;

  function automatic logic [63:0] popped(input logic [63:0] raw);
    logic [63:0] r;
    r = raw;
    r[55:48] = raw[55:48] >> 2;
    return r;
  endfunction

  always @(posedge clk) begin
    mbeat_t b;
    if (reset) begin
      q.delete();
      m_in_hdr = 1'b1;
      m_route  = 2'd0;
      m_ready  = 1'b0;
    end else begin
      if (q.size() > 0 && trdy[q[0].port]) void'(q.pop_front());
      if (I_TVALID && m_ready) begin
        b.raw  = I_TDATA;
        b.last = I_TLAST;
        b.hdr  = m_in_hdr;
        if (m_in_hdr) begin
          b.port  = I_TDATA[49:48];
          m_route = b.port;
        end else begin
          b.port = m_route;
        end
        m_in_hdr = I_TLAST;
        q.push_back(b);
      end
      m_ready = (q.size() < 2);
    end
  end

  logic [3:0]  ev;
  logic [63:0] ed;
  always @(negedge clk) begin
    if (chk_en) begin
      ev = '0;
      if (q.size() > 0) ev[q[0].port] = 1'b1;
      chk("i_tready", I_TREADY, m_ready);
      chk("i_tready_cr0", I_TREADY0, m_ready);
      chk("o_tvalid", ov, ev);
      chk("o_tvalid_cr0", ov0, ev);
      if (q.size() > 0) begin
        ed = q[0].hdr ? popped(q[0].raw) : q[0].raw;
        chk("o_tdata", od[q[0].port], ed);
        chk("o_tdata_cr0", od0[q[0].port], q[0].raw);
        chk("o_tlast", ol[q[0].port], q[0].last);
        chk("o_tlast_cr0", ol0[q[0].port], q[0].last);
      end
    end
  end

  // Holds the beat until accepted; returns on the negedge after acceptance.
  task automatic send(input logic [63:0] d, input logic l);
    int n;
    bit acc;
    n = 0;
    I_TVALID = 1'b1;
    I_TDATA  = d;
    I_TLAST  = l;
    do begin
      acc = I_TREADY;
      @(negedge clk);
      n++;
    end while (!acc && n < 100);
    chk("send_accept", acc, 1'b1);
  endtask

  task automatic idle(input int n);
    I_TVALID = 1'b0;
    I_TDATA  = 64'hDEAD_BEEF_0BAD_F00D;
    I_TLAST  = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1;
    chk("rst_tready", I_TREADY, 1'b0);
    chk("rst_tvalid", ov, 4'b0000);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_tready", I_TREADY, 1'b1);

    // single-beat header E6 -> port 2, SRC_ID 39 (popped) / E6 (kept)
    send(64'h00E6_1234_5678_9ABC, 1'b1);
    chk("t1_valid", ov, 4'b0100);
    chk("t1_src", od[2][55:48], 8'h39);
    chk("t1_rest", {od[2][63:56], od[2][47:0]}, 56'h00_1234_5678_9ABC);
    chk("t1_last", ol[2], 1'b1);
    chk("t6_src_cr0", od0[2][55:48], 8'hE6);
    idle(2);

    // 3-beat packet to port 1, body carries 2'b11 in the route field
    send(64'h00F1_0000_0000_0A01, 1'b0);
    chk("t2_hdr_valid", ov, 4'b0010);
    chk("t2_hdr_src", od[1][55:48], 8'h3C);
    send(64'h0103_0000_0000_00B1, 1'b0);
    chk("t2_b1_data", od[1], 64'h0103_0000_0000_00B1);
    chk("t2_b1_last", ol[1], 1'b0);
    send(64'h0203_0000_0000_00B2, 1'b1);
    chk("t2_b2_valid", ov, 4'b0010);
    chk("t2_b2_last", ol[1], 1'b1);
    idle(2);

    // A (port 0) drains, B (port 3) stalls and fills the FIFO
    trdy[3] = 1'b0;
    send(64'h0000_0000_0000_00A0, 1'b0);
    send(64'h0000_0000_0000_00A1, 1'b1);
    send(64'h0003_0000_0000_00B0, 1'b0);
    send(64'h0000_0000_0000_00B1, 1'b0);
    chk("t3_full", I_TREADY, 1'b0);
    I_TDATA  = 64'h0000_0000_0000_00B2;
    I_TLAST  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t3_stall_rdy", I_TREADY, 1'b0);
      chk("t3_stall_o3", ov, 4'b1000);
    end
    trdy[3] = 1'b1;
    send(64'h0000_0000_0000_00B2, 1'b1);
    idle(4);

    // back-to-back single-beat packets to ports 0,1,2,3,0
    send(64'h0010_0000_0000_0000, 1'b1);
    chk("t4_p0", ov, 4'b0001);
    send(64'h0021_0000_0000_0001, 1'b1);
    chk("t4_p1", ov, 4'b0010);
    send(64'h0032_0000_0000_0002, 1'b1);
    chk("t4_p2", ov, 4'b0100);
    send(64'h0043_0000_0000_0003, 1'b1);
    chk("t4_p3", ov, 4'b1000);
    send(64'h0050_0000_0000_0004, 1'b1);
    chk("t4_p0b", ov, 4'b0001);
    chk("t4_rdy", I_TREADY, 1'b1);
    idle(2);

    // reset mid-packet; next beat is a header to port 0
    trdy[1] = 1'b0;
    send(64'h0005_0000_0000_0C00, 1'b0);
    chk("t5_hdr", ov, 4'b0010);
    I_TVALID = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("t5_rst_valid", ov, 4'b0000);
    chk("t5_rst_rdy", I_TREADY, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    trdy = 4'hF;
    send(64'h0000_0000_0000_0C01, 1'b1);
    chk("t5_new_hdr", ov, 4'b0001);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i_split4.md
Name: i_split4

Overview:
- 1:4 interconnect steering block for the completion/response path, paired with the 4:1 request-path merge.
- Accepts whole packets on one input stream and routes each packet, header to last beat, to one of four outputs.
- The output is selected by the 2-bit routing code in header SRC_ID[1:0] (TDATA[49:48]).
- When CONSUME_ROUTE=1, the code is popped: SRC_ID shifts down by 2, undoing the merge's push.

Parameters:
CONSUME_ROUTE, 1, 1: strip routing code from header SRC_ID (TDATA[55:48] <= {2'b00, TDATA[55:50]}); 0: header passes unmodified.

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
I_TVALID  input  1  input beat valid
I_TREADY  output  1  input beat accepted when I_TVALID && I_TREADY
I_TDATA  input  64  input beat data; header SRC_ID at [55:48]
I_TLAST  input  1  last beat of packet
O0_TVALID..O3_TVALID  output  1 each  output n beat valid
O0_TREADY..O3_TREADY  input  1 each  output n ready
O0_TDATA..O3_TDATA  output  64 each  output n data
O0_TLAST..O3_TLAST  output  1 each  output n last

Behaviour:
- Reset values: storage empty; all On_TVALID=0; I_TREADY=0 during reset, 1 the cycle after; is_header=1; route register=0.
- Storage: 2-entry FIFO. Each entry holds {port[1:0], last, data[63:0]}.
- I_TREADY = (count != 2). It is registered-state-only, with no combinational path from any On_TREADY.
- Push: occurs when I_TVALID && I_TREADY.
- Header beat (is_header=1):
  - port = I_TDATA[49:48]; route register <= port.
  - Stored data is transformed per CONSUME_ROUTE.
  - If !I_TLAST, is_header <= 0.
- Body beat (is_header=0):
  - port = route register; data stored unmodified, even if [49:48] differs.
  - If I_TLAST, is_header <= 1.
- Single-beat packets leave is_header=1. is_header and route update only on push.
- Outputs:
  - On_TVALID = !empty && head.port==n.
  - All On_TDATA/On_TLAST are driven from the FIFO head; only TVALID differs between ports.
  - Pop occurs when the selected port's TREADY=1.
  - Head data is stable while TVALID && !TREADY.
- Latency: a beat pushed in cycle t is valid on its output in cycle t+1.
- Throughput: 1 beat/cycle when the destination is ready.
- Simultaneous push and pop:
  - count=1 → stays 1.
  - count=0 → push only, since the head is not yet valid.
  - count=2 → no push (I_TREADY=0); pop → 1.
- Ordering:
  - Strictly in order; head-of-line blocking is acceptable. A stalled output blocks subsequent packets to other outputs.
  - Packets never interleave on an output.
- Reset mid-packet: FIFO contents discarded, outputs deasserted, is_header=1. The next accepted beat is treated as a header.
- Unknown TLAST/TDATA with TVALID=0 must not affect state.

Test Plan:
1. Single-beat header, I_TDATA[55:48]=8'hE6, CONSUME_ROUTE=1, all TREADY=1 → next cycle O2_TVALID=1 only, O2_TDATA[55:48]=8'h39, other bits equal input, O2_TLAST=1; nothing on O0/O1/O3.
2. 3-beat packet, header [49:48]=2'b01, body beats with [49:48]=2'b11 → all three beats on O1, body data bit-identical to input, TLAST only on beat 3, O3_TVALID never asserts.
3. Packet A (2 beats, port 0) then packet B (3 beats, port 3), O3_TREADY=0:
   - A drains on O0.
   - B's first two beats fill the FIFO; I_TREADY=0 from then on.
   - When O3_TREADY is raised, B completes in order and I_TREADY returns to 1 next cycle.
4. Back-to-back single-beat packets to ports 0,1,2,3,0, inputs always valid, all TREADY=1 → one beat per cycle appears on the matching port, I_TREADY stays 1 throughout.
5. Reset asserted after the header of a 4-beat packet to port 1 → all On_TVALID=0 next cycle. A post-reset beat with [49:48]=2'b00 is treated as a header and emerges on O0.
6. CONSUME_ROUTE=0, header [55:48]=8'hE6 → O2 receives [55:48]=8'hE6 unchanged.
